// File: rtl/grf_wb_arbiter.sv
// Write-port arbiter for the general register file.
// Shares the single GRF write port between pipeline writeback (PL) and the
// multiply/divide unit (MD). MD results are buffered in a small FIFO. PL keeps
// priority until an anti-starvation counter forces an MD grant. A registered
// write stage drives the GRF directly, and a combinational pending-write check
// feeds the hazard unit.
module grf_wb_arbiter #(
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pl_valid,
  output logic        pl_ready,
  input  logic [4:0]  pl_a3,
  input  logic [31:0] pl_wd,
  input  logic [31:0] pl_pc,
  input  logic        md_valid,
  output logic        md_ready,
  input  logic [4:0]  md_a3,
  input  logic [31:0] md_wd,
  input  logic [31:0] md_pc,
  output logic        grf_we,
  output logic [4:0]  grf_a3,
  output logic [31:0] grf_wd,
  output logic [31:0] grf_pc,
  input  logic [4:0]  chk_a1,
  input  logic [4:0]  chk_a2,
  output logic        chk_hit1,
  output logic        chk_hit2
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [3:0]  MAX_WAIT_L = 4'(MAX_WAIT);

  typedef enum logic [0:0] {
    PL_FIRST  = 1'b0,
    MD_FORCED = 1'b1
  } arb_state_e;

  arb_state_e    state_q, state_d;
  logic [3:0]    wait_q, wait_d;

  logic [4:0]    fifo_a3_q [DEPTH];
  logic [31:0]   fifo_wd_q [DEPTH];
  logic [31:0]   fifo_pc_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q, count_d;

  logic          grf_we_q, grf_we_d;
  logic [4:0]    grf_a3_q, grf_a3_d;
  logic [31:0]   grf_wd_q, grf_wd_d;
  logic [31:0]   grf_pc_q, grf_pc_d;

  logic          fifo_empty;
  logic          push;
  logic          grant_md;
  logic          grant_pl;
  logic [PW-1:0] idx;

  assign fifo_empty = (count_q == '0);
  assign md_ready   = (count_q < CW'(DEPTH));
  assign pl_ready   = (state_q == PL_FIRST) || fifo_empty;
  assign push       = md_valid && md_ready;
  assign grant_md   = !fifo_empty && ((state_q == MD_FORCED) || !pl_valid);
  assign grant_pl   = !grant_md && pl_valid;

  assign grf_we = grf_we_q;
  assign grf_a3 = grf_a3_q;
  assign grf_wd = grf_wd_q;
  assign grf_pc = grf_pc_q;

  // Arbitration state and starvation counter next-state
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    if (grant_md) begin
      state_d = PL_FIRST;
      wait_d  = '0;
    end else if (grant_pl && !fifo_empty) begin
      wait_d = wait_q + 4'd1;
      if (wait_d == MAX_WAIT_L) begin
        state_d = MD_FORCED;
      end
    end
  end

  // Arbitration state and starvation counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= PL_FIRST;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // FIFO occupancy: simultaneous push and pop leaves the count unchanged
  always_comb begin
    count_d = count_q;
    case ({push, grant_md})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers and count; reset discards all queued entries
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (grant_md) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

  // FIFO payload storage (validity is tracked by the count alone)
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      fifo_a3_q[wr_ptr_q] <= md_a3;
      fifo_wd_q[wr_ptr_q] <= md_wd;
      fifo_pc_q[wr_ptr_q] <= md_pc;
    end
  end

  // Write stage next-state: $0 writes consume the slot but never enable the GRF
  always_comb begin
    grf_we_d = 1'b0;
    grf_a3_d = grf_a3_q;
    grf_wd_d = grf_wd_q;
    grf_pc_d = grf_pc_q;
    if (grant_md) begin
      grf_a3_d = fifo_a3_q[rd_ptr_q];
      grf_wd_d = fifo_wd_q[rd_ptr_q];
      grf_pc_d = fifo_pc_q[rd_ptr_q];
      grf_we_d = (fifo_a3_q[rd_ptr_q] != 5'd0);
    end else if (grant_pl) begin
      grf_a3_d = pl_a3;
      grf_wd_d = pl_wd;
      grf_pc_d = pl_pc;
      grf_we_d = (pl_a3 != 5'd0);
    end
  end

  // Registered GRF write stage
  always_ff @(posedge clk) begin
    if (reset) begin
      grf_we_q <= 1'b0;
      grf_a3_q <= '0;
      grf_wd_q <= '0;
      grf_pc_q <= '0;
    end else begin
      grf_we_q <= grf_we_d;
      grf_a3_q <= grf_a3_d;
      grf_wd_q <= grf_wd_d;
      grf_pc_q <= grf_pc_d;
    end
  end

  // Pending-write check over valid FIFO entries (walked from head) and the write stage
  always_comb begin
    chk_hit1 = grf_we_q && (grf_a3_q == chk_a1);
    chk_hit2 = grf_we_q && (grf_a3_q == chk_a2);
    idx      = rd_ptr_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count_q) begin
        if (fifo_a3_q[idx] == chk_a1) chk_hit1 = 1'b1;
        if (fifo_a3_q[idx] == chk_a2) chk_hit2 = 1'b1;
      end
      idx = idx + PW'(1);
    end
    if (chk_a1 == 5'd0) chk_hit1 = 1'b0;
    if (chk_a2 == 5'd0) chk_hit2 = 1'b0;
  end

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Directed bench for grf_wb_arbiter with hand-computed expectations.
module tb_grf_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        pl_valid, pl_ready;
  logic [4:0]  pl_a3;
  logic [31:0] pl_wd, pl_pc;
  logic        md_valid, md_ready;
  logic [4:0]  md_a3;
  logic [31:0] md_wd, md_pc;
  logic        grf_we;
  logic [4:0]  grf_a3;
  logic [31:0] grf_wd, grf_pc;
  logic [4:0]  chk_a1, chk_a2;
  logic        chk_hit1, chk_hit2;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  grf_wb_arbiter #(.DEPTH(2), .MAX_WAIT(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .pl_valid (pl_valid),
    .pl_ready (pl_ready),
    .pl_a3    (pl_a3),
    .pl_wd    (pl_wd),
    .pl_pc    (pl_pc),
    .md_valid (md_valid),
    .md_ready (md_ready),
    .md_a3    (md_a3),
    .md_wd    (md_wd),
    .md_pc    (md_pc),
    .grf_we   (grf_we),
    .grf_a3   (grf_a3),
    .grf_wd   (grf_wd),
    .grf_pc   (grf_pc),
    .chk_a1   (chk_a1),
    .chk_a2   (chk_a2),
    .chk_hit1 (chk_hit1),
    .chk_hit2 (chk_hit2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past one rising edge; inputs change and checks happen in the gap.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1;
    pl_valid = 1'b0; pl_a3 = '0; pl_wd = '0; pl_pc = '0;
    md_valid = 1'b0; md_a3 = '0; md_wd = '0; md_pc = '0;
    chk_a1 = 5'd5; chk_a2 = 5'd7;

    // Reset state
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst_we",    grf_we,   0);
    check("rst_a3",    grf_a3,   0);
    check("rst_wd",    grf_wd,   0);
    check("rst_pc",    grf_pc,   0);
    check("rst_plrdy", pl_ready, 1);
    check("rst_mdrdy", md_ready, 1);
    check("rst_hit1",  chk_hit1, 0);
    check("rst_hit2",  chk_hit2, 0);

    // PL single write: one-cycle latency
    pl_valid = 1'b1; pl_a3 = 5'd5; pl_wd = 32'h1234; pl_pc = 32'h3000;
    #1 check("pl_ready", pl_ready, 1);
    tick();
    pl_valid = 1'b0;
    #1;
    check("pl_we",   grf_we,   1);
    check("pl_a3",   grf_a3,   5);
    check("pl_wd",   grf_wd,   32'h1234);
    check("pl_pc",   grf_pc,   32'h3000);
    check("pl_hit1", chk_hit1, 1);
    tick();
    #1;
    check("pl_we_off",   grf_we,   0);
    check("pl_hit1_off", chk_hit1, 0);

    // MD single write: two-cycle latency through the FIFO
    md_valid = 1'b1; md_a3 = 5'd7; md_wd = 32'hAAAA; md_pc = 32'h4000;
    #1;
    check("md_ready",        md_ready, 1);
    check("md_hit2_incoming", chk_hit2, 0);
    tick();
    md_valid = 1'b0;
    #1;
    check("md_we_queued",   grf_we,   0);
    check("md_hit2_queued", chk_hit2, 1);
    tick();
    #1;
    check("md_we",         grf_we,   1);
    check("md_a3",         grf_a3,   7);
    check("md_wd",         grf_wd,   32'hAAAA);
    check("md_pc",         grf_pc,   32'h4000);
    check("md_hit2_fly",   chk_hit2, 1);
    tick();
    #1;
    check("md_we_off",   grf_we,   0);
    check("md_hit2_off", chk_hit2, 0);

    // Starvation: PL saturating, one MD entry, forced after 4 PL wins
    pl_valid = 1'b1; pl_a3 = 5'd1; pl_wd = 32'h11; pl_pc = 32'h100;
    md_valid = 1'b1; md_a3 = 5'd9; md_wd = 32'hBBBB; md_pc = 32'h5000;
    tick();
    md_valid = 1'b0;
    chk_a1 = 5'd9;
    #1 check("sv_hit_q", chk_hit1, 1);
    for (int k = 0; k < 4; k++) begin
      pl_a3 = 5'(2 + k);
      #1 check("sv_plrdy", pl_ready, 1);
      tick();
      #1;
      check("sv_pl_we", grf_we, 1);
      check("sv_pl_a3", grf_a3, 32'(2 + k));
    end
    pl_a3 = 5'd6;
    #1 check("sv_forced", pl_ready, 0);
    tick();
    #1;
    check("sv_md_a3",  grf_a3,   9);
    check("sv_md_wd",  grf_wd,   32'hBBBB);
    check("sv_plrdy2", pl_ready, 1);
    tick();
    #1;
    check("sv_pl_resume", grf_a3, 6);
    pl_valid = 1'b0;
    tick();

    // $0 write: slot consumed, no write enable, no hazard on $0
    pl_valid = 1'b1; pl_a3 = 5'd0; pl_wd = 32'hFFFF; pl_pc = 32'h6000;
    tick();
    pl_valid = 1'b0;
    chk_a1 = 5'd0;
    #1;
    check("z_we",   grf_we,   0);
    check("z_wd",   grf_wd,   32'hFFFF);
    check("z_hit1", chk_hit1, 0);

    // FIFO full with PL saturating, then reset mid-operation
    pl_valid = 1'b1; pl_a3 = 5'd3; pl_wd = 32'h33; pl_pc = 32'h7000;
    md_valid = 1'b1; md_a3 = 5'd11; md_wd = 32'hB1;
    tick();
    md_a3 = 5'd12; md_wd = 32'hC1;
    #1 check("f_mdrdy1", md_ready, 1);
    tick();
    md_a3 = 5'd13; md_wd = 32'hD1;
    for (int k = 0; k < 3; k++) begin
      #1 check("f_full", md_ready, 0);
      tick();
    end
    #1;
    check("f_full4",  md_ready, 0);
    check("f_forced", pl_ready, 0);
    tick();
    #1;
    check("f_pop_a3", grf_a3,   11);
    check("f_space",  md_ready, 1);
    tick();
    md_valid = 1'b0;
    chk_a1 = 5'd13; chk_a2 = 5'd12;
    #1;
    check("f_pl_a3",  grf_a3,   3);
    check("f_full5",  md_ready, 0);
    check("f_hit13",  chk_hit1, 1);
    check("f_hit12",  chk_hit2, 1);

    reset = 1'b1; pl_valid = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    check("r_we",    grf_we,   0);
    check("r_mdrdy", md_ready, 1);
    check("r_plrdy", pl_ready, 1);
    check("r_hit1",  chk_hit1, 0);
    check("r_hit2",  chk_hit2, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      #1 check("r_no_emerge", grf_we, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
